supersonic: RTL and testbench



---
 rtl/supersonic_pkg.sv | 24 ++
 rtl/supersonic_echo_sync.sv | 34 +++
 rtl/supersonic.sv | 178 +++++++++++++++++
 tb/tb_supersonic.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/supersonic_pkg.sv
// supersonic_pkg: state encoding and default timing constants for the
// ultrasonic ranging front end. Shared with the cut controller bench.
package supersonic_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_ECHO = 3'd2,
        ECHO      = 3'd3,
        DONE      = 3'd4,
        HOLDOFF   = 3'd5
    } state_e;

    // Defaults assume a 50 MHz clock.
    localparam int DEF_TRIG_CYC    = 500;        // 10 us sensor trigger
    localparam int DEF_CYC_PER_MM  = 292;        // round trip at 343 m/s
    localparam int DEF_TIMEOUT_CYC = 1_900_000;  // 38 ms
    localparam int DEF_HOLDOFF_CYC = 3_000_000;  // 60 ms
    localparam int DEF_DIST_W      = 32;

    localparam int CNT_W = 22;  // shared cycle counter, covers HOLDOFF
    localparam int SUB_W = 9;   // per-millimetre sub-counter

endpackage

// File: rtl/supersonic_echo_sync.sv
// echo_sync: 2-flop synchronizer for the asynchronous echo pin plus
// registered single-cycle rise/fall pulses of the synchronized level.
module echo_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic echo_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, s3_q;
    logic rise_q, fall_q;

    // Synchronize, keep one delayed copy, and register the edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= echo_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
            fall_q <= ~s2_q & s3_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/supersonic.sv
// supersonic: HC-SR04 ranging front end. Drives the trigger pin, times the
// echo pulse and reports floor(width / CYC_PER_MM) millimetres.
// Optional feature: SUPERSONIC_TIMEOUT_EN adds an echo timeout that reports
// all-ones ("no target"); without it a lost echo waits until reset.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   IDLE      | waiting for trigger request
//   TRIG      | sensor trigger pin high for TRIG_CYC cycles
//   WAIT_ECHO | waiting for synchronized echo rise
//   ECHO      | counting echo width into mm accumulator
//   DONE      | result strobe cycle (valid high, distance updated)
//   HOLDOFF   | dead time of HOLDOFF_CYC cycles before next request
module supersonic
    import supersonic_pkg::*;
#(
    parameter int TRIG_CYC    = DEF_TRIG_CYC,
    parameter int CYC_PER_MM  = DEF_CYC_PER_MM,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC,
    parameter int DIST_W      = DEF_DIST_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger,
    output logic              triggerSuc,
    output logic              valid,
    output logic [DIST_W-1:0] distance,
    output logic              sr_trig,
    input  logic              sr_echo
);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CYC_PER_MM - 1);
`ifdef SUPERSONIC_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
`endif

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SUB_W-1:0]    sub_q, sub_d, sub_step;
    logic [DIST_W-1:0]   acc_q, acc_d, acc_step;
    logic [DIST_W-1:0]   dist_q, dist_d;
    logic                trig_q, trig_d;
    logic                suc_q, suc_d;
    logic                valid_q, valid_d;
    logic                echo_rise, echo_fall;

    echo_sync u_echo_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .echo_i (sr_echo),
        .rise_o (echo_rise),
        .fall_o (echo_fall)
    );

    // One echo cycle: advance the sub-counter, carry into the saturating mm count.
    always_comb begin
        sub_step = sub_q + 1'b1;
        acc_step = acc_q;
        if (sub_q == SUB_LAST) begin
            sub_step = '0;
            if (acc_q != '1) acc_step = acc_q + 1'b1;
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        sub_d   = sub_q;
        acc_d   = acc_q;
        dist_d  = dist_q;
        trig_d  = 1'b0;
        suc_d   = 1'b0;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = TRIG;
                    trig_d  = 1'b1;
                end
            end
            TRIG: begin
                cnt_d  = cnt_q + 1'b1;
                trig_d = 1'b1;
                if (cnt_q == TRIG_LAST) begin
                    cnt_d   = '0;
                    trig_d  = 1'b0;
                    suc_d   = 1'b1;
                    state_d = WAIT_ECHO;
                end
            end
            WAIT_ECHO: begin
`ifdef SUPERSONIC_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (echo_rise) begin
                    state_d = ECHO;
                    cnt_d   = '0;
                    sub_d   = '0;
                    acc_d   = '0;
                end
`ifdef SUPERSONIC_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    dist_d  = '1;
                end
`endif
            end
            ECHO: begin
                // The rise cycle is spent entering ECHO and the fall cycle is
                // still counted, so the total equals the synchronized width.
                sub_d = sub_step;
                acc_d = acc_step;
`ifdef SUPERSONIC_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (echo_fall) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    dist_d  = acc_step;
                end
`ifdef SUPERSONIC_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    dist_d  = '1;
                end
`endif
            end
            DONE: begin
                state_d = HOLDOFF;
            end
            HOLDOFF: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sub_q   <= '0;
            acc_q   <= '0;
            dist_q  <= '0;
            trig_q  <= 1'b0;
            suc_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            acc_q   <= acc_d;
            dist_q  <= dist_d;
            trig_q  <= trig_d;
            suc_q   <= suc_d;
            valid_q <= valid_d;
        end
    end

    assign sr_trig    = trig_q;
    assign triggerSuc = suc_q;
    assign valid      = valid_q;
    assign distance   = dist_q;

endmodule

// File: tb/tb_supersonic.sv
// tb_supersonic: directed bench for the supersonic ranging front end, run
// with shortened timeout/holdoff so the whole sequence stays small.
module tb_supersonic;

    localparam int TRIG_CYC    = 500;
    localparam int CYC_PER_MM  = 292;
    localparam int TIMEOUT_CYC = 3000;
    localparam int HOLDOFF_CYC = 1000;
    localparam int DIST_W      = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              trigger = 1'b0;
    logic              sr_echo = 1'b0;
    logic              triggerSuc;
    logic              valid;
    logic              sr_trig;
    logic [DIST_W-1:0] distance;

    int total = 0;
    int bad   = 0;

    supersonic #(
        .TRIG_CYC    (TRIG_CYC),
        .CYC_PER_MM  (CYC_PER_MM),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .HOLDOFF_CYC (HOLDOFF_CYC),
        .DIST_W      (DIST_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trigger    (trigger),
        .triggerSuc (triggerSuc),
        .valid      (valid),
        .distance   (distance),
        .sr_trig    (sr_trig),
        .sr_echo    (sr_echo)
    );

    always #10 clk = ~clk;

    initial begin
        #(20 * 98000);
        $display("FAIL watchdog: simulation exceeded cycle limit");
        $fatal(1);
    end

    // Waits for sr_trig, measures its width and where triggerSuc appears.
    task automatic measure_trig(input int rise_budget, output int delay, output int width,
                                output int suc_fall, output int suc_other);
        delay = 0; width = 0; suc_fall = 0; suc_other = 0;
        while (sr_trig !== 1'b1 && delay < rise_budget) begin
            if (triggerSuc === 1'b1) suc_other++;
            @(negedge clk);
            delay++;
        end
        while (sr_trig === 1'b1 && width < 2 * TRIG_CYC) begin
            if (triggerSuc === 1'b1) suc_other++;
            width++;
            @(negedge clk);
        end
        if (triggerSuc === 1'b1) suc_fall = 1;
        repeat (4) begin
            @(negedge clk);
            if (triggerSuc === 1'b1) suc_other++;
        end
    endtask

    task automatic drive_echo(input int w);
        sr_echo = 1'b1;
        repeat (w) @(negedge clk);
        sr_echo = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int seen,
                              output logic [DIST_W-1:0] d, output int after);
        int n;
        n = 0; seen = 0; d = '0; after = 0;
        while (valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (valid === 1'b1) begin
            seen = 1;
            d = distance;
            @(negedge clk);
            if (valid === 1'b1) after = 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; trigger = 1'b0; sr_echo = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (sr_trig !== 1'b0) begin bad++; $display("FAIL reset_sr_trig got=%b want=0", sr_trig); end
        total++; if (triggerSuc !== 1'b0) begin bad++; $display("FAIL reset_triggerSuc got=%b want=0", triggerSuc); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++; if (distance !== '0) begin bad++; $display("FAIL reset_distance got=%0d want=0", distance); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (sr_trig !== 1'b0) begin bad++; $display("FAIL idle_no_trig got=%b want=0", sr_trig); end
    endtask

    task automatic test_trigger();
        int dl, w, sf, so;
        trigger = 1'b1;
        measure_trig(5, dl, w, sf, so);
        total++; if (dl < 1 || dl > 2) begin bad++; $display("FAIL trig_latency got=%0d want=1..2", dl); end
        total++; if (w != TRIG_CYC) begin bad++; $display("FAIL trig_width got=%0d want=%0d", w, TRIG_CYC); end
        total++; if (sf != 1) begin bad++; $display("FAIL suc_on_fall got=%0d want=1", sf); end
        total++; if (so != 0) begin bad++; $display("FAIL suc_extra got=%0d want=0", so); end
    endtask

    task automatic test_distance_100();
        int seen, after;
        logic [DIST_W-1:0] d;
        repeat (3) @(negedge clk);
        drive_echo(29200);
        wait_valid(10, seen, d, after);
        total++; if (seen != 1) begin bad++; $display("FAIL d100_valid got=%0d want=1", seen); end
        total++; if (d !== 32'd100) begin bad++; $display("FAIL d100_distance got=%0d want=100", d); end
        total++; if (after != 0) begin bad++; $display("FAIL d100_valid_width got=%0d want=0", after); end
        trigger = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (distance !== 32'd100) begin bad++; $display("FAIL d100_hold got=%0d want=100", distance); end
        repeat (HOLDOFF_CYC + 10) @(negedge clk);
    endtask

    task automatic test_truncation();
        int dl, w, sf, so, seen, after;
        logic [DIST_W-1:0] d;
        trigger = 1'b1;
        measure_trig(5, dl, w, sf, so);
        total++; if (w != TRIG_CYC) begin bad++; $display("FAIL trunc_trig_width got=%0d want=%0d", w, TRIG_CYC); end
        repeat (3) @(negedge clk);
        drive_echo(CYC_PER_MM * 101 - 1);
        wait_valid(10, seen, d, after);
        total++; if (seen != 1) begin bad++; $display("FAIL trunc_valid got=%0d want=1", seen); end
        total++; if (d !== 32'd100) begin bad++; $display("FAIL trunc_distance got=%0d want=100", d); end
    endtask

    // Entered right after the truncation result with trigger still high.
    task automatic test_holdoff();
        int dl, w, sf, so, seen, after, nv, nt;
        logic [DIST_W-1:0] d;
        sr_echo = 1'b1;
        measure_trig(HOLDOFF_CYC + 20, dl, w, sf, so);
        total++; if (dl < HOLDOFF_CYC || dl > HOLDOFF_CYC + 4)
            begin bad++; $display("FAIL holdoff_delay got=%0d want=%0d..%0d", dl, HOLDOFF_CYC, HOLDOFF_CYC + 4); end
        total++; if (w != TRIG_CYC) begin bad++; $display("FAIL holdoff_trig_width got=%0d want=%0d", w, TRIG_CYC); end
        total++; if (sf != 1 || so != 0) begin bad++; $display("FAIL holdoff_suc got=%0d/%0d want=1/0", sf, so); end
        trigger = 1'b0;
        repeat (6) @(negedge clk);
        sr_echo = 1'b0;
        trigger = 1'b1;
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) trigger = 1'b0;
            if (valid === 1'b1) nv++;
        end
        total++; if (nv != 0) begin bad++; $display("FAIL stray_echo_valid got=%0d want=0", nv); end
        drive_echo(3 * CYC_PER_MM);
        wait_valid(10, seen, d, after);
        total++; if (seen != 1 || d !== 32'd3) begin bad++; $display("FAIL d3_distance got=%0d/%0d want=1/3", seen, d); end
        nt = 0;
        for (int i = 0; i < HOLDOFF_CYC + 50; i++) begin
            @(negedge clk);
            if (sr_trig === 1'b1) nt++;
        end
        total++; if (nt != 0) begin bad++; $display("FAIL no_queue got=%0d want=0", nt); end
    endtask

    task automatic test_timeout();
        int dl, w, sf, so;
`ifdef SUPERSONIC_TIMEOUT_EN
        int seen, after;
        logic [DIST_W-1:0] d;
`else
        int nv;
`endif
        trigger = 1'b1;
        measure_trig(5, dl, w, sf, so);
        trigger = 1'b0;
        total++; if (w != TRIG_CYC) begin bad++; $display("FAIL to_trig_width got=%0d want=%0d", w, TRIG_CYC); end
`ifdef SUPERSONIC_TIMEOUT_EN
        wait_valid(TIMEOUT_CYC + 20, seen, d, after);
        total++; if (seen != 1) begin bad++; $display("FAIL timeout_valid got=%0d want=1", seen); end
        total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL timeout_distance got=%h want=ffffffff", d); end
        repeat (HOLDOFF_CYC + 10) @(negedge clk);
`else
        nv = 0;
        for (int i = 0; i < 2 * TIMEOUT_CYC + 1000; i++) begin
            @(negedge clk);
            if (valid === 1'b1) nv++;
        end
        total++; if (nv != 0) begin bad++; $display("FAIL no_timeout_valid got=%0d want=0", nv); end
`endif
    endtask

    task automatic test_reset_abort();
        int n, hits, dl, w, sf, so;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        trigger = 1'b1;
        n = 0;
        while (sr_trig !== 1'b1 && n < 5) begin @(negedge clk); n++; end
        repeat (200) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++; if (sr_trig !== 1'b0) begin bad++; $display("FAIL abort_sr_trig got=%b want=0", sr_trig); end
        trigger = 1'b0;
        hits = 0;
        repeat (3) begin
            @(negedge clk);
            if (triggerSuc === 1'b1 || valid === 1'b1) hits++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (triggerSuc === 1'b1 || valid === 1'b1 || sr_trig === 1'b1) hits++;
        end
        total++; if (hits != 0) begin bad++; $display("FAIL abort_quiet got=%0d want=0", hits); end
        trigger = 1'b1;
        measure_trig(5, dl, w, sf, so);
        trigger = 1'b0;
        total++; if (w != TRIG_CYC || sf != 1) begin bad++; $display("FAIL abort_idle_retrig got=%0d/%0d want=%0d/1", w, sf, TRIG_CYC); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_trigger();
        test_distance_100();
        test_truncation();
        test_holdoff();
        test_timeout();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
